// File: rtl/uart_stop_check.sv
// Stop-bit checker: holds the assembled RX word, majority-votes three mid-bit samples
// per stop bit, then releases the word or reports a framing error / break.
module uart_stop_check #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              check_stop,
    input  logic              data_in,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              stop_err,
    output logic              break_det,
    output logic              done,
    output logic              busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] S0_TICK   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] S1_TICK   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] S2_TICK   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [0:0]    LAST_BIT  = 1'(STOP_BITS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_STOP = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic              bit_idx_q, bit_idx_d;
    logic              s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              stop_err_q, stop_err_d;
    logic              break_det_q, break_det_d;
    logic              done_q, done_d;
    logic              vote2;
    logic              bit_good;

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_idx_d    = bit_idx_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        stop_err_d   = stop_err_q;
        data_valid_d = 1'b0;
        break_det_d  = 1'b0;
        done_d       = 1'b0;
        // With OVERSAMPLE=4 the third sample falls on the decision tick, so vote on the live line.
        vote2    = (tick_q == S2_TICK) ? data_in : s2_q;
        bit_good = (s0_q & s1_q) | (s0_q & vote2) | (s1_q & vote2);

        case (state_q)
            ST_IDLE: begin
                if (check_stop) begin
                    hold_d     = rx_data;
                    stop_err_d = 1'b0;
                    tick_d     = '0;
                    bit_idx_d  = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            default: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == S0_TICK) s0_d = data_in;
                if (tick_q == S1_TICK) s1_d = data_in;
                if (tick_q == S2_TICK) s2_d = data_in;
                if (tick_q == LAST_TICK) begin
                    tick_d = '0;
                    if (!bit_good) begin
                        stop_err_d  = 1'b1;
                        data_out_d  = '0;
                        done_d      = 1'b1;
                        break_det_d = (hold_q == '0);
                        state_d     = ST_IDLE;
                    end else if (bit_idx_q == LAST_BIT) begin
                        data_out_d   = hold_q;
                        data_valid_d = 1'b1;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        bit_idx_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_idx_q    <= 1'b0;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            hold_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
            break_det_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_idx_q    <= bit_idx_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            stop_err_q   <= stop_err_d;
            break_det_q  <= break_det_d;
            done_q       <= done_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign stop_err   = stop_err_q;
    assign break_det  = break_det_q;
    assign done       = done_q;
    assign busy       = (state_q == ST_STOP);

endmodule

// File: tb/tb_uart_stop_check.sv
// Bench for uart_stop_check: one instance with one stop bit, one with two, driven by
// directed and random frames and checked against a per-frame vote model.
module tb_uart_stop_check;

    localparam int OS = 16;
    localparam int M  = OS / 2;

    logic       clk;
    logic       rst_n;
    logic       data_in;
    logic [7:0] rx_data;
    logic       cs1, cs2;
    logic [7:0] do1, do2;
    logic       dv1, dv2, se1, se2, bd1, bd2, dn1, dn2, bz1, bz2;

    int checks   = 0;
    int failures = 0;
    int sel      = 1;
    logic       line_v[32];
    logic [7:0] exp_do[1:2];
    logic       exp_err[1:2];

    logic [7:0] o_do;
    logic       o_dv, o_se, o_bd, o_dn, o_bz;

    uart_stop_check #(.DATA_W(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .check_stop(cs1), .data_in(data_in), .rx_data(rx_data),
        .data_out(do1), .data_valid(dv1), .stop_err(se1), .break_det(bd1), .done(dn1), .busy(bz1)
    );

    uart_stop_check #(.DATA_W(8), .OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .check_stop(cs2), .data_in(data_in), .rx_data(rx_data),
        .data_out(do2), .data_valid(dv2), .stop_err(se2), .break_det(bd2), .done(dn2), .busy(bz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel == 1) begin
            o_do = do1; o_dv = dv1; o_se = se1; o_bd = bd1; o_dn = dn1; o_bz = bz1;
        end else begin
            o_do = do2; o_dv = dv2; o_se = se2; o_bd = bd2; o_dn = dn2; o_bz = bz2;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cs(input logic v);
        if (sel == 1) cs1 = v; else cs2 = v;
    endtask

    task automatic set_all(input logic v);
        for (int j = 0; j < 32; j++) line_v[j] = v;
    endtask

    function automatic logic [7:0] rand_word();
        return ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    endfunction

    task automatic fill_random();
        for (int j = 0; j < 32; j++) begin
            if ((j % OS) >= M - 1 && (j % OS) <= M + 1) line_v[j] = 1'($urandom_range(0, 1));
            else line_v[j] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_busy", o_bz, 0);
            chk("idle_done", o_dn, 0);
            chk("idle_valid", o_dv, 0);
            chk("idle_stop_err", o_se, exp_err[sel]);
            chk("idle_data_out", o_do, exp_do[sel]);
        end
    endtask

    // One frame on the selected instance; line_v[j] is the line level during cycle T+1+j.
    task automatic run_frame(input logic [7:0] word, input bit pre_started, input int repulse_j,
                             input bit chain, input logic [7:0] next_word);
        int nbits, fail_bit, len, ones;
        nbits    = (sel == 1) ? 1 : 2;
        fail_bit = -1;
        for (int b = 0; b < nbits; b++) begin
            if (fail_bit < 0) begin
                ones = 0;
                for (int k = M - 1; k <= M + 1; k++) ones += int'(line_v[b * OS + k]);
                if (ones < 2) fail_bit = b;
            end
        end
        len = ((fail_bit < 0) ? nbits : fail_bit + 1) * OS;

        if (!pre_started) begin
            @(negedge clk);
            set_cs(1'b1);
            rx_data = word;
        end
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            set_cs(j == repulse_j);
            rx_data = (j == repulse_j) ? ~word : 8'($urandom);
            data_in = line_v[j];
            chk("run_busy", o_bz, 1);
            chk("run_done", o_dn, 0);
            chk("run_valid", o_dv, 0);
            chk("run_stop_err", o_se, 0);
            chk("run_data_out", o_do, exp_do[sel]);
        end
        @(negedge clk);
        set_cs(1'b0);
        data_in = 1'b1;
        exp_err[sel] = (fail_bit >= 0);
        exp_do[sel]  = (fail_bit >= 0) ? 8'h00 : word;
        chk("end_done", o_dn, 1);
        chk("end_valid", o_dv, (fail_bit < 0));
        chk("end_stop_err", o_se, exp_err[sel]);
        chk("end_break", o_bd, (fail_bit >= 0) && (word == 8'h00));
        chk("end_data_out", o_do, exp_do[sel]);
        chk("end_busy", o_bz, 0);
        if (chain) begin
            set_cs(1'b1);
            rx_data = next_word;
        end else begin
            @(negedge clk);
            chk("post_done", o_dn, 0);
            chk("post_valid", o_dv, 0);
            chk("post_break", o_bd, 0);
            chk("post_stop_err", o_se, exp_err[sel]);
            chk("post_data_out", o_do, exp_do[sel]);
        end
    endtask

    task automatic random_frames(input int s, input int n);
        logic [7:0] w, nw;
        bit pre, ch;
        sel = s;
        pre = 0;
        w   = rand_word();
        for (int i = 0; i < n; i++) begin
            fill_random();
            nw = rand_word();
            ch = (i < n - 1) && ($urandom_range(0, 1) == 1);
            run_frame(w, pre, -1, ch, nw);
            pre = ch;
            w   = nw;
        end
    endtask

    initial begin
        rst_n = 1'b0; cs1 = 1'b0; cs2 = 1'b0; data_in = 1'b1; rx_data = 8'h00;
        exp_do[1] = 8'h00; exp_do[2] = 8'h00; exp_err[1] = 1'b0; exp_err[2] = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 1; s <= 2; s++) begin
            sel = s;
            #0;
            chk("rst_data_out", o_do, 0);
            chk("rst_valid", o_dv, 0);
            chk("rst_stop_err", o_se, 0);
            chk("rst_break", o_bd, 0);
            chk("rst_done", o_dn, 0);
            chk("rst_busy", o_bz, 0);
        end
        rst_n = 1'b1;
        sel = 1;
        idle_check(2);

        set_all(1); run_frame(8'hA5, 0, -1, 0, 8'h00);
        set_all(1); line_v[7] = 0; line_v[8] = 0; line_v[9] = 0;
        run_frame(8'h3C, 0, -1, 0, 8'h00);
        idle_check(4);
        set_all(0); run_frame(8'h00, 0, -1, 0, 8'h00);
        set_all(1); run_frame(8'h5A, 0, -1, 0, 8'h00);
        set_all(1); line_v[8] = 0; run_frame(8'hC3, 0, -1, 0, 8'h00);
        set_all(1); line_v[8] = 0; line_v[9] = 0; run_frame(8'h81, 0, -1, 0, 8'h00);
        set_all(1); run_frame(8'h77, 0, 4, 0, 8'h00);
        set_all(1); run_frame(8'h11, 0, -1, 1, 8'h22);
        set_all(1); run_frame(8'h22, 1, -1, 0, 8'h00);

        sel = 2;
        set_all(1); for (int j = 16; j < 32; j++) line_v[j] = 0;
        run_frame(8'hF0, 0, -1, 0, 8'h00);
        set_all(0); run_frame(8'hF0, 0, -1, 0, 8'h00);
        idle_check(16);
        set_all(1); run_frame(8'h00, 0, -1, 0, 8'h00);

        // Reset in the middle of a check aborts it without done or valid.
        sel = 1;
        @(negedge clk); cs1 = 1'b1; rx_data = 8'h99;
        repeat (8) begin @(negedge clk); cs1 = 1'b0; end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_do[1] = 8'h00; exp_do[2] = 8'h00; exp_err[1] = 1'b0; exp_err[2] = 1'b0;
        chk("abort_data_out", o_do, 0);
        chk("abort_done", o_dn, 0);
        chk("abort_busy", o_bz, 0);
        idle_check(20);

        random_frames(1, 24);
        random_frames(2, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
